// File: rtl/mmcm_multi_phase_shifter.sv
// Multi-channel MMCM dynamic phase-shift sequencer: one PSEN per step with a PSDONE handshake,
// per-channel signed phase-position accumulators, abort, timeout and bad-channel reporting.
module mmcm_multi_phase_shifter #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned STEP_W  = 12,
    parameter int unsigned POS_W   = 16,
    parameter int unsigned GAP     = 4,
    parameter int unsigned TIMEOUT = 1023,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic                  cmd_dir,
    input  logic [STEP_W-1:0]     cmd_steps,
    input  logic                  abort,
    output logic [N_CH-1:0]       psen,
    output logic [N_CH-1:0]       psincdec,
    input  logic [N_CH-1:0]       psdone,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  bad_ch_err,
    output logic [N_CH*POS_W-1:0] pos
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic                dir;
    logic [STEP_W-1:0]   remaining;
    logic [TMR_W-1:0]    timer;
    logic [GAP_W-1:0]    gap_cnt;
    logic                abort_q;
    logic [N_CH-1:0]     ch_mask;
    logic [N_CH-1:0]     cmd_mask;
    logic                psdone_sel;
    logic                stop_req;
    logic [POS_W-1:0]    step_val;

    // One-hot decodes of the active channel and of the incoming command channel
    always_comb begin
        ch_mask  = '0;
        cmd_mask = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_mask[k]  = (ch == CH_W'(k));
            cmd_mask[k] = (cmd_ch == CH_W'(k));
        end
    end

    assign cmd_ready  = (state == S_IDLE);
    assign psdone_sel = |(psdone & ch_mask);
    assign stop_req   = abort | abort_q;
    assign step_val   = dir ? POS_W'(1) : {POS_W{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ch          <= '0;
            dir         <= 1'b0;
            remaining   <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            abort_q     <= 1'b0;
            psen        <= '0;
            psincdec    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            bad_ch_err  <= 1'b0;
            pos         <= '0;
        end else begin
            psen <= '0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ch          <= cmd_ch;
                        dir         <= cmd_dir;
                        remaining   <= cmd_steps;
                        abort_q     <= 1'b0;
                        timeout_err <= 1'b0;
                        bad_ch_err  <= 1'b0;
                        // cmd_mask is all-zero for an out-of-range channel, so no psincdec bit moves
                        psincdec    <= (psincdec & ~cmd_mask) | (cmd_mask & {N_CH{cmd_dir}});
                        if (cmd_mask == '0) begin
                            bad_ch_err <= 1'b1;
                            done       <= 1'b1;
                        end else if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            psen  <= cmd_mask;
                            state <= S_PULSE;
                        end
                    end
                end
                S_PULSE: begin
                    abort_q <= stop_req;
                    timer   <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    abort_q <= stop_req;
                    if (psdone_sel) begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (ch_mask[k]) begin
                                pos[k*POS_W +: POS_W] <= pos[k*POS_W +: POS_W] + step_val;
                            end
                        end
                        remaining <= remaining - STEP_W'(1);
                        if (remaining == STEP_W'(1) || stop_req) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else if (GAP == 0) begin
                            psen  <= ch_mask;
                            state <= S_PULSE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_GAP: begin
                    if (stop_req) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (gap_cnt == GAP_W'(GAP - 1)) begin
                        psen  <= ch_mask;
                        state <= S_PULSE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
